// File: rtl/mux_rr_stream.sv
`default_nettype none
// ============================================================================
// mux_rr_stream : CH_NUM-to-1 valid/ready stream mux with a registered output,
//                 explicit select or work-conserving round-robin arbitration.
// Revision      : 1.0
// ============================================================================
module mux_rr_stream #(
  parameter int CH_NUM = 4,
  parameter int DW     = 2,
  parameter int SW     = $clog2(CH_NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SW-1:0]        sel,
  input  logic [CH_NUM-1:0]    in_valid,
  input  logic [CH_NUM*DW-1:0] in_data,
  output logic [CH_NUM-1:0]    in_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [SW-1:0]        out_ch,
  input  logic                 out_ready
);

  localparam logic [SW-1:0] c_last_ch = SW'(CH_NUM - 1);

  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [SW-1:0] r_out_ch;
  logic [SW-1:0] r_ptr;

  logic          w_load_en;
  logic          w_sel_hit;
  logic          w_rr_hi_found;
  logic [SW-1:0] w_rr_hi_idx;
  logic          w_rr_lo_found;
  logic [SW-1:0] w_rr_lo_idx;
  logic          w_grant_found;
  logic [SW-1:0] w_grant_idx;
  logic [DW-1:0] w_grant_data;
  logic          w_in_xfer;
  logic [SW-1:0] w_ptr_next;

  assign w_load_en = !r_out_valid || out_ready;

  // Comparing against every legal index means an out-of-range sel simply never hits.
  always_comb begin
    w_sel_hit = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if ((sel == SW'(i)) && in_valid[i]) begin
        w_sel_hit = 1'b1;
      end
    end
  end

  // Lowest valid index at or above ptr, else lowest valid index overall (wrap).
  always_comb begin
    w_rr_hi_found = 1'b0;
    w_rr_hi_idx   = '0;
    w_rr_lo_found = 1'b0;
    w_rr_lo_idx   = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        w_rr_lo_found = 1'b1;
        w_rr_lo_idx   = SW'(i);
        if (SW'(i) >= r_ptr) begin
          w_rr_hi_found = 1'b1;
          w_rr_hi_idx   = SW'(i);
        end
      end
    end
  end

  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    if (!mode) begin
      w_grant_found = w_sel_hit;
      w_grant_idx   = sel;
    end else if (w_rr_hi_found) begin
      w_grant_found = 1'b1;
      w_grant_idx   = w_rr_hi_idx;
    end else begin
      w_grant_found = w_rr_lo_found;
      w_grant_idx   = w_rr_lo_idx;
    end
  end

  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (w_grant_idx == SW'(i)) begin
        w_grant_data = in_data[i*DW +: DW];
      end
    end
  end

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ready
    assign in_ready[gi] = w_grant_found && w_load_en && (w_grant_idx == SW'(gi));
  end

  assign w_in_xfer  = w_grant_found && w_load_en;
  assign w_ptr_next = (w_grant_idx == c_last_ch) ? '0 : (w_grant_idx + SW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_in_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_grant_data;
        r_out_ch    <= w_grant_idx;
        if (mode) begin
          r_ptr <= w_ptr_next;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_stream.sv
`default_nettype none
// ============================================================================
// tb_mux_rr_stream : three parameter sets run side by side, each against a
//                    cycle model plus per-channel scoreboard queues.
// Revision         : 1.0
// ============================================================================
module tb_mux_rr_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_cfg
    localparam int CH = (k == 0) ? 4 : (k == 1) ? 3 : 8;
    localparam int W  = (k == 0) ? 2 : (k == 1) ? 8 : 16;
    localparam int S  = $clog2(CH);

    logic            rst_n;
    logic            mode;
    logic [S-1:0]    sel;
    logic [CH-1:0]   in_valid;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [S-1:0]    out_ch;
    logic            out_ready;

    int n_cmp = 0;
    int n_err = 0;
    bit fin   = 1'b0;

    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_ch;
    int           m_ptr;
    logic [W-1:0] sbq [CH][$];
    int           log_ch[$];
    logic [W-1:0] log_data[$];
    int           exp_ch[$];
    logic [W-1:0] exp_dat[$];

    mux_rr_stream #(.CH_NUM(CH), .DW(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_ready (out_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", k, name, act, exp, $time);
      end
    endtask

    // Grant straight from the arbitration rules: a select hit, or a circular scan from ptr.
    function automatic int grant(input logic [CH-1:0] v, input logic m, input int s, input int p);
      if (!m) begin
        if (s >= CH) return -1;
        return v[s] ? s : -1;
      end
      for (int j = 0; j < CH; j++) begin
        if (v[(p + j) % CH]) return (p + j) % CH;
      end
      return -1;
    endfunction

    function automatic logic [CH*W-1:0] rnd_data();
      logic [CH*W-1:0] d;
      for (int j = 0; j < CH; j++) d[j*W +: W] = W'($urandom);
      return d;
    endfunction

    task automatic m_clear();
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = 0;
      m_ptr   = 0;
      for (int c = 0; c < CH; c++) sbq[c].delete();
      log_ch.delete();
      log_data.delete();
    endtask

    task automatic check_outs();
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("out_data", 64'(out_data), 64'(m_data));
      check("out_ch", 64'(out_ch), 64'(m_ch));
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic cyc(input logic nm, input int ns, input logic [CH-1:0] nv,
                       input logic [CH*W-1:0] nd, input logic nr);
      int            g;
      int            c;
      logic          le;
      logic [CH-1:0] exp_rdy;
      check_outs();
      mode      = nm;
      sel       = S'(ns);
      in_valid  = nv;
      in_data   = nd;
      out_ready = nr;
      #1;
      g       = grant(nv, nm, ns, m_ptr);
      le      = !m_valid || nr;
      exp_rdy = '0;
      if (g >= 0 && le) exp_rdy[g] = 1'b1;
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (out_valid === 1'b1 && nr) begin
        c = int'(out_ch);
        log_ch.push_back(c);
        log_data.push_back(out_data);
        check("sb_ch_range", 64'(c < CH), 64'(1));
        if (c < CH) begin
          check("sb_word_pending", 64'(sbq[c].size() != 0), 64'(1));
          if (sbq[c].size() != 0) check("sb_data", 64'(out_data), 64'(sbq[c].pop_front()));
        end
      end
      @(posedge clk);
      if (g >= 0 && le) begin
        m_valid = 1'b1;
        m_data  = nd[g*W +: W];
        m_ch    = g;
        sbq[g].push_back(m_data);
        if (nm) m_ptr = (g + 1) % CH;
      end else if (m_valid && nr) begin
        m_valid = 1'b0;
      end
      @(negedge clk);
    endtask

    task automatic do_reset();
      logic [CH-1:0] exp_rdy;
      int            g;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
        mode      = 1'($urandom);
        sel       = S'($urandom);
        in_valid  = CH'($urandom);
        in_data   = rnd_data();
        out_ready = 1'($urandom);
        @(negedge clk);
      end
      m_clear();
      check_outs();
      g       = grant(in_valid, mode, int'(sel), 0);
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("rst_in_ready", 64'(in_ready), 64'(exp_rdy));
      rst_n = 1'b1;
    endtask

    task automatic drain();
      for (int i = 0; i < 4 && m_valid; i++) cyc(mode, int'(sel), '0, '0, 1'b1);
    endtask

    task automatic check_log(input string nm, input bit use_dat);
      check({nm, "_count"}, 64'(log_ch.size()), 64'(exp_ch.size()));
      for (int i = 0; i < exp_ch.size() && i < log_ch.size(); i++) begin
        check({nm, "_ch"}, 64'(log_ch[i]), 64'(exp_ch[i]));
        if (use_dat) check({nm, "_data"}, 64'(log_data[i]), 64'(exp_dat[i]));
      end
      log_ch.delete();
      log_data.delete();
      exp_ch.delete();
      exp_dat.delete();
    endtask

    initial begin : p_run
      logic [CH*W-1:0] d_idx;
      int              s_top;
      logic            rmode;
      bit              bp [10];

      rst_n     = 1'b0;
      mode      = 1'b0;
      sel       = '0;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;
      do_reset();

      // Explicit select: channel j carries the value j.
      for (int j = 0; j < CH; j++) d_idx[j*W +: W] = W'(j);
      for (int s = 0; s < CH; s++) begin
        cyc(1'b0, s, '1, d_idx, 1'b1);
        exp_ch.push_back(s);
        exp_dat.push_back(W'(s));
      end
      drain();
      check_log("explicit", 1'b1);

      // Highest encodable select: out of range unless CH is a power of two.
      s_top = (1 << S) - 1;
      for (int i = 0; i < 3; i++) begin
        cyc(1'b0, s_top, '1, d_idx, 1'b1);
        if (s_top < CH) begin
          exp_ch.push_back(s_top);
          exp_dat.push_back(W'(s_top));
        end
      end
      drain();
      check_log("sel_top", 1'b1);

      // Round-robin fairness with every channel always valid.
      do_reset();
      for (int i = 0; i < 2 * CH; i++) begin
        cyc(1'b1, 0, '1, rnd_data(), 1'b1);
        exp_ch.push_back(i % CH);
      end
      drain();
      check_log("rr_fair", 1'b0);

      // Skip: only channels 1 and CH-1 request.
      for (int i = 0; i < 4; i++) begin
        cyc(1'b1, 0, CH'((1 << 1) | (1 << (CH - 1))), rnd_data(), 1'b1);
        exp_ch.push_back((i % 2 == 0) ? 1 : CH - 1);
      end
      drain();
      check_log("rr_skip", 1'b0);

      // Wrap: the last channel alone is granted back to back.
      for (int i = 0; i < 3; i++) begin
        cyc(1'b1, 0, CH'(1 << (CH - 1)), rnd_data(), 1'b1);
        exp_ch.push_back(CH - 1);
      end
      drain();
      check_log("rr_wrap", 1'b0);

      // Backpressure: five stalled cycles, nothing lost or reordered.
      do_reset();
      bp = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
      for (int i = 0; i < 10; i++) cyc(1'b1, 0, '1, d_idx, 1'(bp[i]));
      drain();
      for (int i = 0; i < 5; i++) begin
        exp_ch.push_back(i % CH);
        exp_dat.push_back(W'(i % CH));
      end
      check_log("backpressure", 1'b1);

      // Asynchronous reset while a word is held.
      cyc(1'b1, 0, '1, rnd_data(), 1'b1);
      check("pre_rst_valid", 64'(out_valid), 64'(m_valid));
      rst_n = 1'b0;
      #1;
      m_clear();
      check_outs();
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b1, 0, '1, rnd_data(), 1'b1);
      check("rst_restart_ch", 64'(out_ch), 64'(0));
      drain();

      // Random traffic with occasional mode flips.
      rmode = 1'b1;
      for (int t = 0; t < 500; t++) begin
        if ($urandom_range(0, 15) == 0) rmode = ~rmode;
        cyc(rmode, int'($urandom_range(0, (1 << S) - 1)), CH'($urandom), rnd_data(),
            1'($urandom_range(0, 3) != 0));
      end
      drain();
      for (int c = 0; c < CH; c++) check("sb_leftover", 64'(sbq[c].size()), 64'(0));
      fin = 1'b1;
    end
  end

  initial begin : p_main
    int tot_cmp;
    int tot_err;
    bit all_fin;
    all_fin = 1'b0;
    for (int i = 0; i < 20000 && !all_fin; i++) begin
      @(posedge clk);
      all_fin = g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin;
    end
    #2;
    tot_cmp = g_cfg[0].n_cmp + g_cfg[1].n_cmp + g_cfg[2].n_cmp + 1;
    tot_err = g_cfg[0].n_err + g_cfg[1].n_err + g_cfg[2].n_err;
    if (!all_fin) begin
      tot_err++;
      $display("FAIL completion: got %0d%0d%0d expected 111", g_cfg[0].fin, g_cfg[1].fin, g_cfg[2].fin);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", tot_cmp, tot_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_rr_stream.md
# mux_rr_stream

Parametrised N-channel streaming multiplexer with a registered output and valid/ready handshakes on every port. It merges CH_NUM producer streams into one consumer stream. Channel choice is either an explicit select, as in the existing combinational 4:1 mux, or work-conserving round-robin arbitration. It sits between per-channel producers and a single shared downstream consumer, and sustains one transfer per cycle.

## Interface
- CH_NUM, 4: number of input channels, ≥2.
- DW, 2: data width per channel, ≥1.
- SW, $clog2(CH_NUM): select/channel-index width. Derived; do not override.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = explicit select, 1 = round-robin.
- sel  in  SW  channel used in explicit mode; ignored in round-robin mode.
- in_valid  in  CH_NUM  per-channel valid; bit i belongs to channel i.
- in_data  in  CH_NUM*DW  channel i occupies bits [i*DW +: DW].
- in_ready  out  CH_NUM  per-channel ready; at most one bit set.
- out_valid  out  1  output register holds a word.
- out_data  out  DW  registered data word.
- out_ch  out  SW  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts the word.

## Operation
- Input transfer on channel i: in_valid[i] && in_ready[i] at a clock edge. Output transfer: out_valid && out_ready at a clock edge.
- Load enable: load_en = !out_valid || out_ready. The output register can accept a new word when it is empty or is being drained in the same cycle.
- Grant g is computed combinationally from in_valid, mode, sel and the priority pointer ptr.
  - Explicit mode: g = sel if sel < CH_NUM and in_valid[sel]; otherwise no grant. An out-of-range sel never grants and never stalls other logic.
  - Round-robin mode: g is the first channel with in_valid set, searching ptr, ptr+1, … wrapping modulo CH_NUM. If no channel is valid, there is no grant.
- in_ready[g] = load_en when a grant exists. All other in_ready bits are 0. in_ready depends combinationally on in_valid; producers must not derive in_valid from in_ready.
- On an input transfer: out_data ← in_data[g], out_ch ← g, out_valid ← 1.
- On an output transfer with no input transfer: out_valid ← 0. out_data and out_ch hold their values.
- With out_valid=1 and out_ready=0, out_data and out_ch stay stable until accepted.
- Priority pointer ptr (SW bits, values 0..CH_NUM-1):
  - Updates only on an input transfer in round-robin mode: ptr ← (g+1) mod CH_NUM. When g = CH_NUM-1, ptr wraps to 0. Non-power-of-2 CH_NUM must wrap correctly.
  - Holds in explicit mode.
- A change of mode or sel takes effect on the next grant evaluation. A word already in the output register is unaffected.

## Timing
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_ch=0, ptr=0. in_ready is therefore driven by grant alone, with load_en=1.
- Deassertion of rst_n is synchronised externally. The first grant is evaluated in the first cycle after release.
- Latency is 1 cycle from input transfer to out_valid/out_data.
- Throughput is 1 word per cycle when out_ready is held at 1.
- Simultaneous output and input transfer in the same cycle: the register reloads and out_valid stays 1. No bubble is inserted.
- Reset asserted mid-stream: the held word is discarded, with no output transfer. Round-robin restarts from channel 0.
- No combinational path from out_ready to out_valid/out_data. There is a combinational path from out_ready to in_ready.

## Test plan
- Reset check: hold rst_n=0 with random inputs; after 2 cycles, out_valid=0, out_data=0, out_ch=0 and all in_ready bits follow grant with load_en=1. Then assert rst_n=0 while out_valid=1; outputs clear immediately without waiting for a clock edge.
- Explicit mode, DW=2: mode=0, all channels valid with data 0,1,2,3, out_ready=1. Step sel 0→3 → out_data 0,1,2,3 and out_ch 0..3 on consecutive cycles, with 1-cycle latency. Then set sel to an unused index with CH_NUM=3 → in_ready stays 0 and out_valid drops.
- Round-robin fairness: mode=1, all 4 channels continuously valid, out_ready=1 → out_ch sequence 0,1,2,3,0,1… with no idle cycles.
- Round-robin skip and wrap: only ch1 and ch3 valid → out_ch alternates 1,3,1,3. With only ch3 valid after a grant to ch3 → ptr wraps to 0 and ch3 is granted again on the next cycle.
- Backpressure: stream in round-robin, hold out_ready=0 for 5 cycles → out_data and out_ch stay stable, in_ready is all 0, and no input is lost. Release out_ready → the remaining words appear in the expected round-robin order.
- Parameter sweep: CH_NUM=3, DW=8 and CH_NUM=8, DW=16 under random valid/ready traffic, checked against a scoreboard model → every accepted input word appears exactly once, in order per channel, with the correct out_ch.
